// File: rtl/sat_mem_pkg.sv
// Shared types for the learned-clause DDR write path:
// word size, clause header layout and writer FSM states.
package sat_mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [15:0] rsvd;
    logic [15:0] len;
  } clause_hdr_t;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DRAIN,
    REQ,
    WRITE,
    DONE
  } wr_state_e;

endpackage

// File: rtl/clause_lit_buffer.sv
// Literal buffer for one clause: one write port, one registered read port.
// Ports: clk; wr_en/wr_addr/wr_data write side; rd_addr -> rd_data next cycle.
module clause_lit_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [15:0]      wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [15:0]      rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  // Prefetch may run one past the clause end; such reads are ignored.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < 16'(DEPTH)))
      mem[wr_addr[AW-1:0]] <= wr_data;
    if (rd_addr < 16'(DEPTH))
      rd_data <= mem[rd_addr[AW-1:0]];
  end

endmodule

// File: rtl/learned_clause_writer.sv
// Buffers one learned clause, allocates DDR space, writes header + literals.
// Ports: lit_* stream in, alloc_* allocator, mem_wr_* DDR, done_*/overflow_err.
module learned_clause_writer
  import sat_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int LIT_WIDTH      = 32,
  parameter int MAX_CLAUSE_LEN = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lit_valid,
  output logic                  lit_ready,
  input  logic [LIT_WIDTH-1:0]  lit_data,
  input  logic                  lit_last,
  output logic                  alloc_req,
  output logic [15:0]           alloc_size,
  input  logic                  alloc_grant,
  input  logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [31:0]           mem_wr_data,
  output logic                  done_valid,
  output logic [ADDR_WIDTH-1:0] done_addr,
  output logic [15:0]           done_len,
  output logic                  overflow_err
);

  wr_state_e state, state_n;

  logic [15:0]           cnt;
  logic [15:0]           clause_len;
  logic [15:0]           len_n;
  logic [15:0]           wr_idx;
  logic [15:0]           rd_idx;
  logic [ADDR_WIDTH-1:0] base;
  logic [LIT_WIDTH-1:0]  rd_data;
  clause_hdr_t           hdr;

  logic beat, full, store, ovf;
  logic accept, last_word, take;

  assign beat      = lit_valid && lit_ready;
  assign full      = (cnt == 16'(MAX_CLAUSE_LEN));
  assign accept    = mem_wr_valid && mem_wr_ready;
  assign last_word = accept && (wr_idx == clause_len);
  assign take      = (state == REQ) && alloc_grant;
  assign hdr       = '{rsvd: 16'h0, len: clause_len};

  always_comb begin
    state_n = state;
    store   = 1'b0;
    ovf     = 1'b0;
    unique case (state)
      IDLE, COLLECT: begin
        if (beat) begin
          if (full) begin
            ovf     = 1'b1;
            state_n = lit_last ? IDLE : DRAIN;
          end else begin
            store   = 1'b1;
            state_n = lit_last ? REQ : COLLECT;
          end
        end
      end
      DRAIN: if (beat && lit_last) state_n = IDLE;
      REQ:   if (alloc_grant) state_n = WRITE;
      WRITE: if (last_word) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign len_n = (store && lit_last) ? cnt + 16'd1 : clause_len;

  // rd_data always holds the literal for the word after the one on the bus.
  assign rd_idx = (state == WRITE) ? wr_idx + {15'b0, accept} : '0;

  clause_lit_buffer #(
    .DEPTH(MAX_CLAUSE_LEN),
    .WIDTH(LIT_WIDTH)
  ) u_buf (
    .clk    (clk),
    .wr_en  (store),
    .wr_addr(cnt),
    .wr_data(lit_data),
    .rd_addr(rd_idx),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      clause_len   <= '0;
      wr_idx       <= '0;
      base         <= '0;
      lit_ready    <= 1'b0;
      overflow_err <= 1'b0;
      alloc_req    <= 1'b0;
      alloc_size   <= '0;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      done_valid   <= 1'b0;
      done_addr    <= '0;
      done_len     <= '0;
    end else begin
      if (ovf || (store && lit_last)) cnt <= '0;
      else if (store)                 cnt <= cnt + 16'd1;
      clause_len   <= len_n;
      lit_ready    <= state_n inside {IDLE, COLLECT, DRAIN};
      overflow_err <= ovf;
      alloc_req    <= (state_n == REQ);
      alloc_size   <= (state_n == REQ) ? len_n + 16'd1 : '0;
      if (take) begin
        base         <= alloc_addr;
        wr_idx       <= '0;
        mem_wr_valid <= 1'b1;
        mem_wr_addr  <= alloc_addr;
        mem_wr_data  <= hdr;
      end else if ((state == WRITE) && accept) begin
        wr_idx       <= wr_idx + 16'd1;
        mem_wr_addr  <= mem_wr_addr + ADDR_WIDTH'(WORD_BYTES);
        mem_wr_data  <= 32'(rd_data);
        if (last_word) mem_wr_valid <= 1'b0;
      end
      done_valid <= (state_n == DONE);
      done_addr  <= (state_n == DONE) ? base : '0;
      done_len   <= (state_n == DONE) ? clause_len : '0;
    end
  end

endmodule

// File: tb/tb_learned_clause_writer.sv
// Directed bench for learned_clause_writer with write/done scoreboards.
// Drives literals and allocator grants; monitor checks DDR writes and done.
module tb_learned_clause_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lit_valid;
  logic        lit_ready;
  logic [31:0] lit_data;
  logic        lit_last;
  logic        alloc_req;
  logic [15:0] alloc_size;
  logic        alloc_grant;
  logic [31:0] alloc_addr;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        done_valid;
  logic [31:0] done_addr;
  logic [15:0] done_len;
  logic        overflow_err;

  learned_clause_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lit_valid   (lit_valid),
    .lit_ready   (lit_ready),
    .lit_data    (lit_data),
    .lit_last    (lit_last),
    .alloc_req   (alloc_req),
    .alloc_size  (alloc_size),
    .alloc_grant (alloc_grant),
    .alloc_addr  (alloc_addr),
    .mem_wr_valid(mem_wr_valid),
    .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .done_valid  (done_valid),
    .done_addr   (done_addr),
    .done_len    (done_len),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_wr[$];
  logic [47:0] exp_done[$];
  logic [31:0] lit_tab [70];

  int ready_mode = 0;
  int cyc = 0;
  int last_acc = 0;
  int done_cnt = 0;
  int ovf_cnt = 0;
  bit alloc_seen = 0;
  bit prev_stall = 0;
  logic [31:0] prev_addr, prev_data;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (ready_mode == 0)      mem_wr_ready = 1'b1;
    else if (ready_mode == 1) mem_wr_ready = 1'($urandom_range(0, 1));
    else                      mem_wr_ready = 1'b0;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(mem_wr_valid), 64'd1);
        check("hold_addr", 64'(mem_wr_addr), 64'(prev_addr));
        check("hold_data", 64'(mem_wr_data), 64'(prev_data));
      end
      if (mem_wr_valid && mem_wr_ready) begin
        if (exp_wr.size() == 0) begin
          check("wr_extra", 64'(exp_wr.size()), 64'd1);
        end else begin
          logic [63:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", 64'(mem_wr_addr), 64'(e[63:32]));
          check("wr_data", 64'(mem_wr_data), 64'(e[31:0]));
        end
        last_acc = cyc;
      end
      prev_stall = mem_wr_valid && !mem_wr_ready;
      prev_addr  = mem_wr_addr;
      prev_data  = mem_wr_data;
      if (done_valid) begin
        if (exp_done.size() == 0) begin
          check("done_extra", 64'(exp_done.size()), 64'd1);
        end else begin
          logic [47:0] d;
          d = exp_done.pop_front();
          check("done_addr", 64'(done_addr), 64'(d[47:16]));
          check("done_len", 64'(done_len), 64'(d[15:0]));
          check("wr_count", 64'(exp_wr.size()), 64'd0);
          if (ready_mode == 0)
            check("done_lat", 64'(cyc), 64'(last_acc + 1));
        end
        done_cnt++;
      end
      if (overflow_err) ovf_cnt++;
      if (alloc_req) alloc_seen = 1;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_lit_ready"}, 64'(lit_ready), 64'd0);
    check({tag, "_alloc_req"}, 64'(alloc_req), 64'd0);
    check({tag, "_alloc_size"}, 64'(alloc_size), 64'd0);
    check({tag, "_wr_valid"}, 64'(mem_wr_valid), 64'd0);
    check({tag, "_wr_addr"}, 64'(mem_wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(mem_wr_data), 64'd0);
    check({tag, "_done_valid"}, 64'(done_valid), 64'd0);
    check({tag, "_done_addr"}, 64'(done_addr), 64'd0);
    check({tag, "_done_len"}, 64'(done_len), 64'd0);
    check({tag, "_ovf"}, 64'(overflow_err), 64'd0);
  endtask

  task automatic push_lit(input logic [31:0] d, input bit last);
    int t = 0;
    lit_valid = 1'b1;
    lit_data  = d;
    lit_last  = last;
    while (!lit_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("lit_timeout", 64'(lit_ready), 64'd1);
    @(negedge clk);
    lit_valid = 1'b0;
    lit_last  = 1'b0;
  endtask

  task automatic send_lits(input int n);
    for (int i = 0; i < n; i++) push_lit(lit_tab[i], i == n - 1);
  endtask

  task automatic grant(input logic [31:0] base, input int n, input int gd);
    int t = 0;
    while (!alloc_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("alloc_req", 64'(alloc_req), 64'd1);
    check("alloc_size", 64'(alloc_size), 64'(n + 1));
    repeat (gd) @(negedge clk);
    check("alloc_hold", 64'(alloc_req), 64'd1);
    alloc_grant = 1'b1;
    alloc_addr  = base;
    @(negedge clk);
    alloc_grant = 1'b0;
    alloc_addr  = 32'hDEAD_BEEF;
    check("alloc_drop", 64'(alloc_req), 64'd0);
    check("hdr_valid", 64'(mem_wr_valid), 64'd1);
    check("hdr_addr", 64'(mem_wr_addr), 64'(base));
    check("hdr_data", 64'(mem_wr_data), 64'(n));
  endtask

  task automatic do_clause(input int n, input logic [31:0] base,
                           input int gd);
    int d0;
    int t = 0;
    exp_wr.push_back({base, 32'(n)});
    for (int i = 0; i < n; i++)
      exp_wr.push_back({base + 32'(4 * (i + 1)), lit_tab[i]});
    exp_done.push_back({base, 16'(n)});
    d0 = done_cnt;
    send_lits(n);
    grant(base, n, gd);
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 64'(done_cnt), 64'(d0 + 1));
    @(negedge clk);
  endtask

  initial begin
    int o0;
    rst_n       = 1'b0;
    lit_valid   = 1'b0;
    lit_data    = '0;
    lit_last    = 1'b0;
    alloc_grant = 1'b0;
    alloc_addr  = '0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", 64'(lit_ready), 64'd1);

    lit_tab[0] = 32'd5;
    lit_tab[1] = 32'hFFFF_FFF9;
    lit_tab[2] = 32'd9;
    do_clause(3, 32'h4000_0000, 2);

    lit_tab[0] = 32'h0000_0123;
    do_clause(1, 32'h1000_0100, 0);

    for (int i = 0; i < 70; i++) lit_tab[i] = 32'h100 + 32'(i);
    alloc_seen = 0;
    o0 = ovf_cnt;
    send_lits(65);
    repeat (4) @(negedge clk);
    check("ovf_once", 64'(ovf_cnt), 64'(o0 + 1));
    o0 = ovf_cnt;
    send_lits(67);
    repeat (4) @(negedge clk);
    check("ovf_drain", 64'(ovf_cnt), 64'(o0 + 1));
    check("no_alloc", 64'(alloc_seen), 64'd0);
    check("rdy_after_drop", 64'(lit_ready), 64'd1);

    do_clause(64, 32'h2000_0000, 1);

    for (int i = 0; i < 10; i++) lit_tab[i] = $urandom;
    ready_mode = 1;
    do_clause(10, 32'h3000_0040, 3);
    ready_mode = 0;

    lit_tab[0] = 32'hA;
    lit_tab[1] = 32'hB;
    lit_tab[2] = 32'hC;
    do_clause(3, 32'hFFFF_FFF8, 1);

    ready_mode = 2;
    send_lits(3);
    grant(32'h5000_0000, 3, 0);
    repeat (2) @(negedge clk);
    check("stall_valid", 64'(mem_wr_valid), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_wr.delete();
    exp_done.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    ready_mode = 0;
    @(negedge clk);
    check("rdy_midrst", 64'(lit_ready), 64'd1);
    lit_tab[0] = 32'h77;
    lit_tab[1] = 32'h88;
    do_clause(2, 32'h6000_0000, 2);

    check("sb_empty", 64'(exp_wr.size() + exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
